// File: rtl/pipe_buffer_pkg.sv
// pipe_buffer shared constants and helpers.
// Imported by the pipe_buffer top level.
package pipe_buffer_pkg;

  function automatic int occ_width(int depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/pipe_buffer_stage.sv
// One valid+data register of the elastic chain.
// Data only captures real beats so bubbles leave it untouched.
module pipe_buffer_stage #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             load,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= RESET_DATA;
    end else if (flush) begin
      valid <= 1'b0;
      data  <= RESET_DATA;
    end else if (load) begin
      valid <= up_valid;
      if (up_valid) data <= up_data;
    end
  end

endmodule

// File: rtl/pipe_buffer.sv
// Elastic stallable/flushable register chain, DEPTH stages.
// Optional skid entry in front of stage 0: PIPE_BUFFER_SKID_EN.
module pipe_buffer
  import pipe_buffer_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               DEPTH      = 1,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       flush,
  output logic [$clog2(DEPTH+2)-1:0] occupancy
);

  localparam int OW = occ_width(DEPTH);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH:0]   rdy;
  logic             s0_valid;
  logic [WIDTH-1:0] s0_data;
  logic             in_fire;
  logic             out_fire;

  // A stage can load if it is empty or its successor moves on.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy[i] = !v[i] || rdy[i+1];
    end
  end

`ifdef PIPE_BUFFER_SKID_EN
  logic             sv;
  logic [WIDTH-1:0] sd;
  logic             sk_load;
  logic             sk_up_valid;

  // Park when stage 0 is blocked; drain into stage 0 when it frees.
  assign sk_load     = sv ? rdy[0] : !rdy[0];
  assign sk_up_valid = !sv && in_valid;

  pipe_buffer_stage #(
    .WIDTH      (WIDTH),
    .RESET_DATA (RESET_DATA)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .load     (sk_load),
    .up_valid (sk_up_valid),
    .up_data  (in_data),
    .valid    (sv),
    .data     (sd)
  );

  assign in_ready = !sv && !flush && !reset;
  assign s0_valid = sv || in_valid;
  assign s0_data  = sv ? sd : in_data;
`else
  assign in_ready = rdy[0] && !flush && !reset;
  assign s0_valid = in_valid;
  assign s0_data  = in_data;
`endif

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             up_v;
    logic [WIDTH-1:0] up_d;

    if (i == 0) begin : g_head
      assign up_v = s0_valid;
      assign up_d = s0_data;
    end else begin : g_body
      assign up_v = v[i-1];
      assign up_d = d[i-1];
    end

    pipe_buffer_stage #(
      .WIDTH      (WIDTH),
      .RESET_DATA (RESET_DATA)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .load     (rdy[i]),
      .up_valid (up_v),
      .up_data  (up_d),
      .valid    (v[i]),
      .data     (d[i])
    );
  end

  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else begin
      occupancy <= occupancy + OW'(in_fire) - OW'(out_fire);
    end
  end

endmodule

// File: tb/tb_pipe_buffer.sv
// Scoreboard bench for pipe_buffer (WIDTH=8, DEPTH=3).
// Monitor pops/compares on each output transfer.
module tb_pipe_buffer;

  localparam int         W  = 8;
  localparam int         D  = 3;
  localparam logic [7:0] RD = 8'hC3;
`ifdef PIPE_BUFFER_SKID_EN
  localparam int CAP = D + 1;
`else
  localparam int CAP = D;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       flush;
  logic [2:0] occupancy;

  int         total = 0;
  int         bad = 0;
  int         popped = 0;
  logic [7:0] q[$];
  logic       exp_rdy;

  pipe_buffer #(
    .WIDTH      (W),
    .DEPTH      (D),
    .RESET_DATA (RD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      q.delete();
    end else begin
      chk("occupancy", occupancy, q.size());
`ifdef PIPE_BUFFER_SKID_EN
      exp_rdy = !flush && (q.size() <= D);
`else
      exp_rdy = !flush && (q.size() < D || out_ready);
`endif
      chk("in_ready", in_ready, exp_rdy);
      if (q.size() == 0) chk("out_valid_empty", out_valid, 0);
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_out", 1, 0);
        else chk("out_data", out_data, q[0]);
      end
      if (flush) begin
        q.delete();
      end else begin
        if (in_valid && in_ready) q.push_back(in_data);
        if (out_valid && out_ready && q.size() > 0) begin
          void'(q.pop_front());
          popped++;
        end
      end
    end
  end

  initial begin
    int acc;
    int p0;
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    out_ready = 1'b0;
    flush     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_out_data", out_data, RD);
    in_valid = 1'b0;
    #2 reset = 1'b0;

    // first-beat latency
    tick();
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_c1", out_valid, 0);
    tick();
    @(negedge clk);
    chk("lat_c2", out_valid, 0);
    tick();
    @(negedge clk);
    chk("lat_c3_valid", out_valid, 1);
    chk("lat_c3_data", out_data, 8'hA5);
    repeat (3) tick();

    // streaming
    in_valid = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_data = 8'(i);
      tick();
      if (i >= 3) begin
        @(negedge clk);
        chk("stream_occ", occupancy, 3);
        chk("stream_valid", out_valid, 1);
      end
    end
    in_valid = 1'b0;
    repeat (4) tick();

    // back-pressure
    p0        = popped;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    acc       = 0;
    in_data   = 8'h20;
    repeat (6) begin
      @(negedge clk);
      if (in_ready) acc++;
      tick();
      in_data = 8'(8'h20 + acc);
    end
    chk("stall_accepted", acc, CAP);
    @(negedge clk);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_occ", occupancy, CAP);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    chk("stall_drain_occ", occupancy, 0);
    chk("stall_drain_cnt", popped - p0, CAP);

    // flush with three beats held
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'(8'h30 + i);
      tick();
    end
    in_data = 8'h99;
    flush   = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_occ", occupancy, 0);
    chk("flush_out_valid", out_valid, 0);
    in_valid  = 1'b1;
    in_data   = 8'h77;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_flush_c1", out_valid, 0);
    tick();
    @(negedge clk);
    chk("post_flush_c2", out_valid, 0);
    tick();
    @(negedge clk);
    chk("post_flush_valid", out_valid, 1);
    chk("post_flush_data", out_data, 8'h77);
    repeat (3) tick();

    // random handshakes
    repeat (10000) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom_range(0, 255));
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    chk("rand_drain_occ", occupancy, 0);

    // async reset with a full pipe
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(8'h40 + i);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    p0        = popped;
    #1 reset = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_occ", occupancy, 0);
    chk("arst_out_data", out_data, RD);
    chk("arst_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("arst_no_xfer", popped - p0, 0);
    chk("arst_rel_occ", occupancy, 0);
    chk("arst_rel_valid", out_valid, 0);
    chk("arst_rel_data", out_data, RD);
    chk("arst_rel_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = 8'h5C;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("arst_after_beat", popped - p0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
